// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: state encoding and the
// width helper for the per-core PC-stability counters.
package cpu_run_pkg;

    // Controller states; the encoding is visible on the debug state output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } run_state_t;

    // Bits needed to count from 0 up to stable_cycles inclusive.
    function automatic int stable_cnt_w(input int stable_cycles);
        int n;
        n = (stable_cycles < 1) ? 1 : stable_cycles;
        return (n + 1 <= 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pc_stable_det.sv
// Per-core halt detector. While enabled it samples the core PC every cycle
// and counts consecutive samples equal to the previous one; once the count
// reaches STABLE_CYCLES the core is flagged halted (sticky until clr).
// halt_set is the combinational "flag sets on this edge" look-ahead so the
// controller can finish the run on the same edge the last flag sets.
module pc_stable_det
    import cpu_run_pkg::*;
#(
    parameter int PC_W          = 32,
    parameter int STABLE_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            clr,
    input  logic [PC_W-1:0] pc,
    output logic            halt_set,
    output logic            halted
);

    localparam int SW = stable_cnt_w(STABLE_CYCLES);
    localparam int S_EFF = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;
    // Count value that, together with one more match, completes the run.
    localparam logic [SW-1:0] STABLE_LAST = SW'(S_EFF - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(S_EFF);

    logic [PC_W-1:0] pc_q;
    logic            pc_vld;
    logic [SW-1:0]   stable_cnt;
    logic            pc_match;

    // A comparison is only meaningful once a sample from this run exists,
    // so a stale PC left over from an earlier run can never count as a match.
    assign pc_match = pc_vld && (pc == pc_q);

    // Fires on the edge where the equal-sample run reaches STABLE_CYCLES.
    assign halt_set = en && !halted && pc_match && (stable_cnt >= STABLE_LAST);

    // Sample register, stable counter and sticky halted flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= '0;
            pc_vld     <= 1'b0;
            stable_cnt <= '0;
            halted     <= 1'b0;
        end else if (clr) begin
            pc_vld     <= 1'b0;
            stable_cnt <= '0;
            halted     <= 1'b0;
        end else if (en) begin
            pc_q   <= pc;
            pc_vld <= 1'b1;
            if (halt_set) begin
                halted <= 1'b1;
            end
            if (pc_match) begin
                if (stable_cnt < STABLE_MAX) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end else begin
            // Not sampling (outside RUN, stopped, or already halted): the
            // equal-sample run is broken, start over next time.
            pc_vld     <= 1'b0;
            stable_cnt <= '0;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller gating the clock-enable of NUM_CORES MIPS cores.
// Supports a free run (start), single-step (step) and abort (stop). A run
// ends when every participating core is detected halted (PC unchanged for
// STABLE_CYCLES samples) or when MAX_CYCLES enabled cycles have elapsed.
//
// Control semantics: start and step are single-cycle pulses sampled on the
// rising edge (start wins when both are high); stop is a level sampled every
// RUN cycle and has priority over run completion. There is no handshake;
// every input is accepted on the edge it is seen in the relevant state.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int NUM_CORES     = 1,
    parameter int PC_W          = 32,
    parameter int CNT_W         = 32,
    parameter int MAX_CYCLES    = 20,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      step,
    input  logic                      stop,
    input  logic [NUM_CORES-1:0]      core_mask,
    input  logic [NUM_CORES*PC_W-1:0] pc,
    output logic [NUM_CORES-1:0]      cpu_en,
    output logic                      running,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [NUM_CORES-1:0]      core_halted,
    output logic                      done,
    output logic                      timeout,
    output logic [1:0]                dbg_state
);

    run_state_t           state;
    logic [NUM_CORES-1:0] mask_q;
    logic [NUM_CORES-1:0] halt_set;
    logic [NUM_CORES-1:0] det_en;
    logic                 launch;
    logic                 all_halted;
    logic                 limit_hit;
    logic [CNT_W-1:0]     count_inc;

    // A new run may be launched from IDLE or DONE only.
    assign launch = start && ((state == IDLE) || (state == DONE));

    // Detectors sample only on RUN edges that actually advance the run.
    assign det_en = ((state == RUN) && !stop) ? (mask_q & ~core_halted)
                                              : {NUM_CORES{1'b0}};

    // Saturating increment of the enabled-cycle counter.
    assign count_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count
                                                      : cycle_count + 1'b1;

    // Every participating core is halted after this edge (an empty mask
    // counts as all halted).
    assign all_halted = &(core_halted | halt_set | ~mask_q);

    // This edge brings the counter to the limit; MAX_CYCLES = 0 disables it.
    assign limit_hit = (MAX_CYCLES != 0) && (count_inc == CNT_W'(MAX_CYCLES));

    assign dbg_state = state;

    // Clock enables decode from registered state and flags only.
    always_comb begin
        cpu_en = {NUM_CORES{1'b0}};
        case (state)
            RUN:     cpu_en = mask_q & ~core_halted;
            STEP:    cpu_en = mask_q;
            default: cpu_en = {NUM_CORES{1'b0}};
        endcase
    end

    // One halt detector per core.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_det
        pc_stable_det #(
            .PC_W          (PC_W),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_det (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (det_en[i]),
            .clr      (launch),
            .pc       (pc[i*PC_W +: PC_W]),
            .halt_set (halt_set[i]),
            .halted   (core_halted[i])
        );
    end

    // Run-control FSM with registered running/done/timeout/counter/mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            running     <= 1'b0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            mask_q      <= '0;
        end else if (launch) begin
            state       <= RUN;
            running     <= 1'b1;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            mask_q      <= core_mask;
        end else begin
            case (state)
                IDLE: begin
                    if (step) begin
                        state   <= STEP;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort: counter and halt flags keep their values.
                        state   <= IDLE;
                        running <= 1'b0;
                    end else begin
                        if (|cpu_en) begin
                            cycle_count <= count_inc;
                        end
                        if (all_halted) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                            timeout <= 1'b0;
                        end else if (limit_hit) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    // Exactly one enabled cycle, then back to IDLE.
                    state       <= IDLE;
                    running     <= 1'b0;
                    cycle_count <= count_inc;
                end
                DONE: begin
                    // Hold results; step and stop are ignored here.
                    state <= DONE;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. dut_a: 2 cores, limit 64. dut_b: 1 core,
// limit 20. Both share clock, reset and the start/step/stop controls.
module tb_cpu_run_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        step;
    logic        stop;

    logic [1:0]  mask_a;
    logic [63:0] pc_a;
    logic [1:0]  en_a;
    logic        run_a;
    logic [31:0] cnt_a;
    logic [1:0]  halt_a;
    logic        done_a;
    logic        to_a;
    logic [1:0]  st_a;

    logic [0:0]  mask_b;
    logic [31:0] pc_b;
    logic [0:0]  en_b;
    logic        run_b;
    logic [31:0] cnt_b;
    logic [0:0]  halt_b;
    logic        done_b;
    logic        to_b;
    logic [1:0]  st_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start;
        logic       step;
        logic       stop;
        logic [1:0] en;
        logic       run;
        int         cnt;
        logic       dn;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .NUM_CORES(2), .PC_W(32), .CNT_W(32), .MAX_CYCLES(64), .STABLE_CYCLES(3)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .step(step), .stop(stop),
        .core_mask(mask_a), .pc(pc_a), .cpu_en(en_a), .running(run_a),
        .cycle_count(cnt_a), .core_halted(halt_a), .done(done_a),
        .timeout(to_a), .dbg_state(st_a)
    );

    cpu_run_ctrl #(
        .NUM_CORES(1), .PC_W(32), .CNT_W(32), .MAX_CYCLES(20), .STABLE_CYCLES(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .step(step), .stop(stop),
        .core_mask(mask_b), .pc(pc_b), .cpu_en(en_b), .running(run_b),
        .cycle_count(cnt_b), .core_halted(halt_b), .done(done_b),
        .timeout(to_b), .dbg_state(st_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start   = 1'b0;
        step    = 1'b0;
        stop    = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // PC that advances by 4 per cycle until cycle 'stick', then holds.
    function automatic logic [31:0] ramp(input int k, input int stick);
        int v;
        v = (k < stick) ? k : stick;
        return 32'(v * 4);
    endfunction

    function automatic vec_t mk(input logic s, input logic p, input logic o,
                                input logic [1:0] en, input logic r, input int c,
                                input logic d, input logic [1:0] st);
        vec_t v;
        v.start = s; v.step = p; v.stop = o; v.en = en;
        v.run = r; v.cnt = c; v.dn = d; v.st = st;
        return v;
    endfunction

    initial begin
        // Step/stop table for dut_a: step with reset mask, start, stop, three
        // spaced steps, start+step together, stop held in IDLE.
        tbl.push_back(mk(0, 1, 0, 2'b00, 1, 0, 0, S_STEP));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 1, 0, S_IDLE));
        tbl.push_back(mk(1, 0, 0, 2'b01, 1, 0, 0, S_RUN));
        tbl.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(0, 1, 0, 2'b01, 1, 0, 0, S_STEP));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 1, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 1, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 1, 0, S_IDLE));
        tbl.push_back(mk(0, 1, 0, 2'b01, 1, 1, 0, S_STEP));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 2, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 2, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 2, 0, S_IDLE));
        tbl.push_back(mk(0, 1, 0, 2'b01, 1, 2, 0, S_STEP));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 3, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 3, 0, S_IDLE));
        tbl.push_back(mk(1, 1, 0, 2'b01, 1, 0, 0, S_RUN));
        tbl.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0, S_IDLE));

        mask_a = 2'b00;
        pc_a   = 64'd0;
        mask_b = 1'b0;
        pc_b   = 32'd0;

        // Reset state
        do_reset();
        chk("rst en_a", 64'(en_a), 64'd0);
        chk("rst run_a", 64'(run_a), 64'd0);
        chk("rst cnt_a", 64'(cnt_a), 64'd0);
        chk("rst halt_a", 64'(halt_a), 64'd0);
        chk("rst done_a", 64'(done_a), 64'd0);
        chk("rst to_a", 64'(to_a), 64'd0);
        chk("rst st_a", 64'(st_a), 64'(S_IDLE));
        chk("rst cnt_b", 64'(cnt_b), 64'd0);

        // Halt detection on core 0 of dut_a; dut_b runs with an empty mask.
        mask_a = 2'b01;
        mask_b = 1'b0;
        start_run();
        chk("t1 start st", 64'(st_a), 64'(S_RUN));
        chk("t1 start en", 64'(en_a), 64'h1);
        chk("t1 start cnt", 64'(cnt_a), 64'd0);
        for (int k = 0; k < 20; k++) begin
            pc_a = {32'd0, ramp(k, 16)};
            tick();
            if (k == 0) begin
                chk("empty st_b", 64'(st_b), 64'(S_DONE));
                chk("empty done_b", 64'(done_b), 64'd1);
                chk("empty to_b", 64'(to_b), 64'd0);
                chk("empty cnt_b", 64'(cnt_b), 64'd0);
            end
            if (k == 18) begin
                chk("t1 pre cnt", 64'(cnt_a), 64'd19);
                chk("t1 pre en", 64'(en_a), 64'h1);
                chk("t1 pre halt", 64'(halt_a), 64'd0);
                chk("t1 pre done", 64'(done_a), 64'd0);
            end
        end
        chk("t1 done", 64'(done_a), 64'd1);
        chk("t1 timeout", 64'(to_a), 64'd0);
        chk("t1 cnt", 64'(cnt_a), 64'd20);
        chk("t1 halt", 64'(halt_a), 64'h1);
        chk("t1 en", 64'(en_a), 64'd0);
        chk("t1 st", 64'(st_a), 64'(S_DONE));
        chk("t1 running", 64'(run_a), 64'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("t1 step in done st", 64'(st_a), 64'(S_DONE));
        chk("t1 step in done cnt", 64'(cnt_a), 64'd20);
        chk("t1 step in done en", 64'(en_a), 64'd0);

        // Cycle-limit timeout on dut_b with an always-moving PC.
        do_reset();
        mask_a = 2'b00;
        mask_b = 1'b1;
        start_run();
        for (int k = 0; k < 20; k++) begin
            pc_b = 32'h1000 + 32'(k * 4);
            tick();
            if (k == 18) begin
                chk("t2 pre cnt", 64'(cnt_b), 64'd19);
                chk("t2 pre en", 64'(en_b), 64'h1);
                chk("t2 pre done", 64'(done_b), 64'd0);
            end
        end
        chk("t2 done", 64'(done_b), 64'd1);
        chk("t2 timeout", 64'(to_b), 64'd1);
        chk("t2 cnt", 64'(cnt_b), 64'd20);
        chk("t2 en", 64'(en_b), 64'd0);
        chk("t2 halt", 64'(halt_b), 64'd0);
        tick();
        chk("t2 hold en", 64'(en_b), 64'd0);
        chk("t2 hold cnt", 64'(cnt_b), 64'd20);
        chk("t2 hold st", 64'(st_b), 64'(S_DONE));

        // Table: steps, stop, start-wins-over-step on dut_a.
        do_reset();
        mask_a = 2'b01;
        mask_b = 1'b1;
        for (int r = 0; r < tbl.size(); r++) begin
            start = tbl[r].start;
            step  = tbl[r].step;
            stop  = tbl[r].stop;
            pc_a  = {32'd0, 32'(r * 8)};
            pc_b  = 32'(r * 8);
            tick();
            chk($sformatf("tbl%0d en", r), 64'(en_a), 64'(tbl[r].en));
            chk($sformatf("tbl%0d running", r), 64'(run_a), 64'(tbl[r].run));
            chk($sformatf("tbl%0d cnt", r), 64'(cnt_a), 64'(tbl[r].cnt));
            chk($sformatf("tbl%0d done", r), 64'(done_a), 64'(tbl[r].dn));
            chk($sformatf("tbl%0d st", r), 64'(st_a), 64'(tbl[r].st));
        end
        start = 1'b0;
        step  = 1'b0;
        stop  = 1'b0;

        // Two cores halting at different times.
        do_reset();
        mask_a = 2'b11;
        start_run();
        for (int k = 0; k < 16; k++) begin
            pc_a = {32'h200 + ramp(k, 12), 32'h100 + ramp(k, 5)};
            tick();
            if (k == 7) begin
                chk("t4 c7 halt", 64'(halt_a), 64'd0);
                chk("t4 c7 en", 64'(en_a), 64'h3);
            end
            if (k == 8) begin
                chk("t4 c8 halt", 64'(halt_a), 64'h1);
                chk("t4 c8 en", 64'(en_a), 64'h2);
                chk("t4 c8 done", 64'(done_a), 64'd0);
            end
            if (k == 14) begin
                chk("t4 c14 en", 64'(en_a), 64'h2);
                chk("t4 c14 done", 64'(done_a), 64'd0);
            end
        end
        chk("t4 halt", 64'(halt_a), 64'h3);
        chk("t4 done", 64'(done_a), 64'd1);
        chk("t4 timeout", 64'(to_a), 64'd0);
        chk("t4 cnt", 64'(cnt_a), 64'd16);
        chk("t4 en", 64'(en_a), 64'd0);

        // Asynchronous reset between clock edges mid-run.
        do_reset();
        mask_a = 2'b01;
        start_run();
        for (int k = 0; k < 5; k++) begin
            pc_a = {32'd0, 32'h300 + 32'(k * 4)};
            tick();
        end
        chk("t5 pre cnt", 64'(cnt_a), 64'd5);
        chk("t5 pre en", 64'(en_a), 64'h1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5 async en", 64'(en_a), 64'd0);
        chk("t5 async cnt", 64'(cnt_a), 64'd0);
        chk("t5 async done", 64'(done_a), 64'd0);
        chk("t5 async halt", 64'(halt_a), 64'd0);
        chk("t5 async running", 64'(run_a), 64'd0);
        #2;
        reset_n = 1'b1;
        tick();
        chk("t5 post st", 64'(st_a), 64'(S_IDLE));
        chk("t5 post en", 64'(en_a), 64'd0);
        chk("t5 post cnt", 64'(cnt_a), 64'd0);

        // Halt and limit on the same edge: halt wins.
        do_reset();
        mask_a = 2'b00;
        mask_b = 1'b1;
        start_run();
        for (int k = 0; k < 20; k++) begin
            pc_b = 32'h2000 + ramp(k, 16);
            tick();
            if (k == 18) begin
                chk("t6a pre halt", 64'(halt_b), 64'd0);
                chk("t6a pre cnt", 64'(cnt_b), 64'd19);
            end
        end
        chk("t6a done", 64'(done_b), 64'd1);
        chk("t6a timeout", 64'(to_b), 64'd0);
        chk("t6a halt", 64'(halt_b), 64'h1);
        chk("t6a cnt", 64'(cnt_b), 64'd20);

        // Same, with stop on that edge: stop wins, nothing advances.
        do_reset();
        start_run();
        for (int k = 0; k < 20; k++) begin
            pc_b = 32'h2000 + ramp(k, 16);
            stop = (k == 19);
            tick();
        end
        stop = 1'b0;
        chk("t6b st", 64'(st_b), 64'(S_IDLE));
        chk("t6b done", 64'(done_b), 64'd0);
        chk("t6b timeout", 64'(to_b), 64'd0);
        chk("t6b running", 64'(run_b), 64'd0);
        chk("t6b cnt", 64'(cnt_b), 64'd19);
        chk("t6b halt", 64'(halt_b), 64'd0);
        chk("t6b en", 64'(en_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run controller that gates the clock-enable of one or more MIPS cores.
- Replaces fixed-duration simulation runs with halt detection, single-step and a cycle-limit timeout.
- Sits between the top-level clock and each core's enable input.
- Detects a halted core as one whose PC stays unchanged (jump-to-self idiom) for a programmable number of cycles.

Parameters:
NUM_CORES, 1, number of independently gated cores
PC_W, 32, width of each core's PC
CNT_W, 32, width of the cycle counter
MAX_CYCLES, 20, RUN-cycle limit before timeout; 0 disables the timeout
STABLE_CYCLES, 3, consecutive equal-PC samples that declare a core halted (minimum 1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin a free run
step  in  1  pulse: execute exactly one cycle
stop  in  1  level: abort a run, return to IDLE
core_mask  in  NUM_CORES  cores taking part; latched on start
pc  in  NUM_CORES*PC_W  flattened current PCs; core i occupies [i*PC_W +: PC_W]
cpu_en  out  NUM_CORES  per-core clock enable
running  out  1  high in RUN or STEP
cycle_count  out  CNT_W  enabled cycles since the last start
core_halted  out  NUM_CORES  sticky per-core halt flags
done  out  1  run finished; held until the next start
timeout  out  1  run ended on the cycle limit

Behaviour:
- Reset: asynchronous, active-low. All outputs, state, latched mask, stable counters and PC samples go to 0; state = IDLE. Takes effect mid-operation with no clock edge.
- States: IDLE, RUN, STEP, DONE.
- IDLE:
  - cpu_en = 0.
  - start -> RUN: clear cycle_count, core_halted, done, timeout; latch core_mask.
  - step (without start) -> STEP. If start and step are both high, start wins.
- RUN:
  - cpu_en[i] = mask_q[i] & ~core_halted[i].
  - cycle_count increments each cycle; saturates at all-ones.
  - stop -> IDLE; cycle_count and core_halted hold their values; done stays 0.
- Halt detection, per enabled core:
  - pc[i] is registered each RUN cycle and compared with the previous sample.
  - A match increments stable_cnt[i]; a mismatch clears it.
  - When stable_cnt[i] reaches STABLE_CYCLES, core_halted[i] sets on that edge and cpu_en[i] drops on the following cycle.
  - Stable counters clear on any exit from RUN.
- Completion:
  - When every latched-mask core is halted -> DONE, done = 1, timeout = 0.
  - Otherwise, if MAX_CYCLES != 0 and cycle_count reaches MAX_CYCLES -> DONE, done = 1, timeout = 1.
  - If all-halted and the limit occur in the same cycle, halt wins: timeout = 0.
  - stop takes priority over completion in the same cycle.
- Empty mask: core_mask = 0 at start -> DONE on the next edge, cycle_count = 0, timeout = 0.
- STEP: cpu_en = latched mask for exactly one cycle, cycle_count + 1, then -> IDLE. No halt detection in STEP. Steps from IDLE use the mask latched by the most recent start (0 after reset).
- DONE: cpu_en = 0; done and timeout hold. start -> RUN (same clearing as from IDLE); step is ignored.
- Outputs are registered; cpu_en is decoded from registered state and flags, with no combinational path from any input.

Decomposition:
- Package cpu_run_pkg holds the state encoding constants (IDLE=2'd0, RUN=2'd1, STEP=2'd2, DONE=2'd3) and a shared stable-counter width function (clog2(STABLE_CYCLES+1)).
- One sub-module, pc_stable_det, instantiated NUM_CORES times via generate. It contains the PC sample register, the stable counter and the sticky halted flag, with inputs en and clr.

Test Plan:
1. NUM_CORES=1, MAX_CYCLES=64. start; pc = 0x00, 0x04, ... 0x40 over cycles 0-16, then held at 0x40 -> core_halted=1 after the third equal sample; done=1, timeout=0, cycle_count=20, cpu_en=0 thereafter.
2. MAX_CYCLES=20. start; pc increments every cycle -> done=1, timeout=1, cycle_count=20, cpu_en low from cycle 21.
3. Reset, start with core_mask=1, then stop; three step pulses in IDLE, spaced 4 cycles apart -> three single-cycle cpu_en pulses, cycle_count=3, running high only on those cycles, done=0.
4. NUM_CORES=2, mask=2'b11. core0 PC sticks at cycle 5, core1 at cycle 12 -> cpu_en[0] drops at cycle 9 while cpu_en[1] stays high; done asserts only after core_halted=2'b11.
5. reset_n driven low asynchronously mid-RUN, between clock edges -> cpu_en, cycle_count, done and core_halted are 0 immediately; state IDLE after release.
6. MAX_CYCLES=20, pc stabilises so the halt sets exactly at cycle_count=20 -> done=1, timeout=0. Repeat with stop asserted in that same cycle -> IDLE, done=0.
